fifo_cache_to_main: RTL

Write-back buffer carrying dirty cache lines evicted by the cache controller toward main memory. It is the return path of the main-to-cache line FIFO and holds up to DEPTH evicted lines. It drains them in order to the main-memory write port over a valid/ready handshake. Evictions to a line that is already pending and not at the head are coalesced in place, and a lookup port lets the cache refill path snoop for pending dirty data.

---
 rtl/fifo_cache_to_main.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_cache_to_main.sv
// Write-back buffer for evicted dirty cache lines heading to main memory.
// In-order drain to the memory write port; re-evictions of a pending non-head
// line are merged in place; a snoop port exposes pending dirty data to refills.
module fifo_cache_to_main #(
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int FIFO_WIDTH = 512,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [FIFO_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [FIFO_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [FIFO_WIDTH-1:0] lookup_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    count
);

  logic [FIFO_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PTR_WIDTH-1:0]  rd_ptr, wr_ptr;
  logic [PTR_WIDTH:0]    cnt;

  logic                  push, pop, alloc, merge;
  logic                  co_hit;
  logic [PTR_WIDTH-1:0]  co_idx;
  logic [PTR_WIDTH-1:0]  lk_idx;

  assign count     = cnt;
  assign full      = (cnt == (PTR_WIDTH+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign wb_ready  = ~full;
  assign mem_valid = ~empty;
  assign mem_data  = data_q[rd_ptr];
  assign mem_addr  = addr_q[rd_ptr];

  assign push  = wb_valid & wb_ready;
  assign pop   = mem_valid & mem_ready;
  assign alloc = push & ~co_hit;
  assign merge = push & co_hit;

  // Find a pending non-head entry with the incoming address; the head is
  // excluded because memory may be sampling it this very cycle.
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == wb_addr && PTR_WIDTH'(i) != rd_ptr) begin
        co_hit = 1'b1;
        co_idx = PTR_WIDTH'(i);
      end
    end
  end

  // Snoop walks entries oldest to youngest so the last match is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr + PTR_WIDTH'(k);
      if (valid_q[lk_idx] && addr_q[lk_idx] == lookup_addr) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk_idx];
      end
    end
  end

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      // wr_ptr == rd_ptr only when empty or full, so pop and alloc never
      // touch the same valid bit in one cycle.
      if (alloc) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({alloc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Line storage is not reset; valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (alloc) begin
      data_q[wr_ptr] <= wb_data;
      addr_q[wr_ptr] <= wb_addr;
    end else if (merge) begin
      data_q[co_idx] <= wb_data;
    end
  end

endmodule
